sram_req_ctrl: RTL and testbench

- Request/response front-end for the single-port synchronous byte-write-enable SRAM macro.
- Converts a valid/ready request stream (read or byte-masked write) into the SRAM's ce/we/be/addr/dataw strobes.
- Captures the SRAM's registered read data one cycle later into a 2-entry response FIFO with valid/ready backpressure.
- Sits between cache/LSU request logic and the SRAM array. Preserves request order and sustains one request per cycle when the consumer never stalls.

---
 rtl/sram_req_ctrl.sv | 100 ++++++++++
 tb/tb_sram_req_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// Request/response front-end for a single-port byte-write-enable SRAM macro.
// Issues SRAM strobes on request acceptance and buffers responses in a 2-entry FIFO.
`timescale 1ns/1ps

module sram_req_ctrl #(
  parameter int unsigned  DATA_WIDTH = 64,
  parameter int unsigned  DATA_DEPTH = 1024,
  localparam int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH),
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,

  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BE_WIDTH-1:0]   sram_be,
  output logic [DATA_WIDTH-1:0] sram_dataw,
  input  logic [DATA_WIDTH-1:0] sram_datar
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned OCC_WIDTH  = 3;

  typedef struct packed {
    logic                  wr;
    logic [DATA_WIDTH-1:0] data;
  } rsp_entry_t;

  logic                 acc;
  logic                 pop;
  logic                 push;
  logic                 infl;
  logic                 infl_wr;
  logic [1:0]           cnt;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [OCC_WIDTH-1:0] occ_next;
  rsp_entry_t           push_entry;
  rsp_entry_t           fifo [FIFO_DEPTH];

  assign acc  = req_valid & req_ready;
  assign pop  = rsp_valid & rsp_ready;
  assign push = infl;

  // Credit: entries held plus the access in flight, less what leaves this cycle
  assign occ_next  = OCC_WIDTH'(cnt) + OCC_WIDTH'(infl) - OCC_WIDTH'(pop);
  assign req_ready = rst_n & (occ_next < OCC_WIDTH'(FIFO_DEPTH));

  // SRAM strobes are driven in the acceptance cycle
  assign sram_ce    = acc;
  assign sram_we    = acc & req_write;
  assign sram_addr  = req_addr;
  assign sram_dataw = req_wdata;
  assign sram_be    = req_write ? req_be : '0;

  assign push_entry.wr   = infl_wr;
  assign push_entry.data = infl_wr ? '0 : sram_datar;

  // Stage-1 tracking of the access issued last cycle, plus the response FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl    <= 1'b0;
      infl_wr <= 1'b0;
      cnt     <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      infl    <= acc;
      infl_wr <= acc & req_write;
      if (push) begin
        fifo[wr_ptr] <= push_entry;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign rsp_valid = (cnt != 2'd0);
  assign rsp_write = fifo[rd_ptr].wr;
  assign rsp_rdata = fifo[rd_ptr].data;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural byte-enable SRAM model.
`timescale 1ns/1ps

module tb_sram_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [63:0] rsp_rdata;
  logic        sram_ce;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [7:0]  sram_be;
  logic [63:0] sram_dataw;
  logic [63:0] sram_datar;

  int total = 0;
  int bad   = 0;

  sram_req_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_be    (sram_be),
    .sram_dataw (sram_dataw),
    .sram_datar (sram_datar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: byte-masked write, registered read data
  logic [63:0] mem [1024];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_dataw[8*b +: 8];
      end else begin
        sram_datar <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [9:0] a, input logic [63:0] d,
                       input logic [7:0] be);
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    req_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        tick();
        req_valid = 1'b0;
        return;
      end
      tick();
    end
    req_valid = 1'b0;
    chk("issue_timeout", 64'(req_ready), 64'd1);
  endtask

  function automatic logic [63:0] spat(input int i);
    return {32'hC0DE0000 | 32'(i), 32'(i * 3 + 7)};
  endfunction

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;

    // Reset with a request pending
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_ce",    64'(sram_ce),   64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata,      64'd0);
    tick();
    tick();
    req_valid = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    chk("rel_ready", 64'(req_ready), 64'd1);
    chk("rel_valid", 64'(rsp_valid), 64'd0);

    // Write addr 5 then read it back, consumer always ready
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd5;
    req_wdata = 64'h1122334455667788; req_be = 8'hFF;
    #1;
    chk("wr_ce", 64'(sram_ce), 64'd1);
    chk("wr_we", 64'(sram_we), 64'd1);
    chk("wr_be", 64'(sram_be), 64'hFF);
    tick();
    req_write = 1'b0; req_be = 8'hAA;
    #1;
    chk("rd_ce", 64'(sram_ce), 64'd1);
    chk("rd_we", 64'(sram_we), 64'd0);
    chk("rd_be", 64'(sram_be), 64'd0);
    tick();
    req_valid = 1'b0;
    #1;
    chk("wrsp_valid", 64'(rsp_valid), 64'd1);
    chk("wrsp_write", 64'(rsp_write), 64'd1);
    chk("wrsp_rdata", rsp_rdata,      64'd0);
    tick();
    chk("rrsp_valid", 64'(rsp_valid), 64'd1);
    chk("rrsp_write", 64'(rsp_write), 64'd0);
    chk("rrsp_rdata", rsp_rdata,      64'h1122334455667788);
    tick();
    chk("rrsp_empty", 64'(rsp_valid), 64'd0);

    // Partial write: low four bytes only
    issue(1'b1, 10'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    issue(1'b0, 10'd5, 64'd0, 8'h00);
    #1;
    chk("pw_wrsp", 64'(rsp_write), 64'd1);
    tick();
    chk("pw_rdata", rsp_rdata, 64'h11223344FFFFFFFF);
    chk("pw_write", 64'(rsp_write), 64'd0);
    tick();

    // Zero-byte-enable write still issues and responds
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd5; req_be = 8'h00;
    req_wdata = 64'd0;
    #1;
    chk("be0_ce", 64'(sram_ce), 64'd1);
    chk("be0_we", 64'(sram_we), 64'd1);
    tick();
    req_valid = 1'b0;
    tick();
    chk("be0_rsp", 64'(rsp_valid & rsp_write), 64'd1);
    tick();

    // Preload addresses used below
    issue(1'b1, 10'd1, 64'hA1A1A1A1A1A1A1A1, 8'hFF);
    issue(1'b1, 10'd2, 64'hB2B2B2B2B2B2B2B2, 8'hFF);
    issue(1'b1, 10'd3, 64'hC3C3C3C3C3C3C3C3, 8'hFF);
    for (int i = 0; i < 16; i++) issue(1'b1, 10'(16 + i), spat(i), 8'hFF);
    tick(); tick(); tick();
    chk("pre_empty", 64'(rsp_valid), 64'd0);

    // Backpressure: only two reads fit while the consumer stalls
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd1;
    #1;
    chk("bp_rdy1", 64'(req_ready), 64'd1);
    tick();
    req_addr = 10'd2;
    #1;
    chk("bp_rdy2", 64'(req_ready), 64'd1);
    tick();
    req_addr = 10'd3;
    #1;
    chk("bp_rdy3", 64'(req_ready), 64'd0);
    chk("bp_ce3",  64'(sram_ce),   64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_rdy",   64'(req_ready), 64'd0);
      chk("bp_hold_data",  rsp_rdata,      64'hA1A1A1A1A1A1A1A1);
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_out2", rsp_rdata, 64'hB2B2B2B2B2B2B2B2);
    tick();
    chk("bp_out3", rsp_rdata, 64'hC3C3C3C3C3C3C3C3);
    chk("bp_out3v", 64'(rsp_valid), 64'd1);
    tick();
    chk("bp_empty", 64'(rsp_valid), 64'd0);

    // Streaming: 16 back-to-back reads, responses from the third cycle on
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'(16 + c);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (c < 16) chk("st_rdy", 64'(req_ready), 64'd1);
      if (c < 2) chk("st_lat", 64'(rsp_valid), 64'd0);
      if (c >= 2) begin
        chk("st_valid", 64'(rsp_valid), 64'd1);
        chk("st_data",  rsp_rdata,      spat(c - 2));
      end
      tick();
    end
    chk("st_empty", 64'(rsp_valid), 64'd0);

    // Mid-operation reset with one entry buffered and one access in flight
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd1;
    tick();
    req_addr = 10'd2;
    tick();
    req_addr = 10'd3;
    #1;
    chk("mr_pre_valid", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(rsp_valid), 64'd0);
    chk("mr_rdata", rsp_rdata,      64'd0);
    chk("mr_write", 64'(rsp_write), 64'd0);
    chk("mr_ready", 64'(req_ready), 64'd0);
    chk("mr_ce",    64'(sram_ce),   64'd0);
    req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_stale", 64'(rsp_valid), 64'd0);
    end
    chk("mr_ready_after", 64'(req_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
